countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  8-digit BCD countdown timer (minutnik), the down-counting counterpart of the stopwatch.
//  Digits are entered from DIP switches and aux buttons, then counted down at 100 Hz.
//  The alarm asserts when the count reaches zero.
//  bcd drives numdriver directly: BCD1=bcd[31:28] ... BCD8=bcd[3:0].
// PARAMETERS
//  PRESCALE  120000  clk cycles per count step (12 MHz -> 10 ms)
// PORTS
//  clk      in   1   system clock, 12 MHz
//  reset    in   1   asynchronous, active-low; clears all state immediately
//  dip      in   8   dip[6:4] = digit index (0 = least significant), dip[3:0] = BCD value, dip[7] ignored
//  aux1     in   1   button, active-low: pause / clear / acknowledge
//  aux2     in   1   button, active-low: start / resume / acknowledge
//  aux3     in   1   button, active-low: write digit / acknowledge
//  bcd      out  32  eight BCD digits, digit k at bcd[4k+3:4k]
//  running  out  1   1 while state == RUN
//  paused   out  1   1 while state == PAUSE
//  alarm    out  1   1 while state == DONE
//  tick     out  1   1-cycle pulse on each prescaler wrap (RUN only)
// BEHAVIOUR
//  Reset values: bcd=0, running=0, paused=0, alarm=0, tick=0, prescaler=0, state=IDLE.
//  Button inputs:
//   - Each aux passes through a 2-FF synchronizer and a falling-edge detector (no debounce).
//   - An edge is acted on by the clock edge after it is detected.
//   - Pin low sampled at edge 1 -> outputs change at edge 3.
//   - Holding a button low produces exactly one event.
//  Same-cycle button events: priority aux1 > aux2 > aux3; only the highest is acted on.
//  Prescaler:
//   - Counts 0..PRESCALE-1 only in RUN; holds its value in PAUSE.
//   - Cleared to 0 on IDLE->RUN.
//   - At PRESCALE-1 it wraps to 0 and tick=1 for that one cycle.
//  Decrement:
//   - The 8-digit BCD value minus 1, borrow rippling from digit 0 upward (0 -> 9 with borrow).
//   - Applied on the tick cycle; the new value is visible the next cycle.
//  States:
//   IDLE:  - aux3 writes min(dip[3:0],9) into digit dip[6:4]; other digits unchanged.
//          - aux2 -> RUN if bcd != 0, otherwise stay in IDLE (ignored).
//          - aux1 clears bcd to 0.
//   RUN:   - Decrement on every tick. If the decremented value is 0 -> DONE.
//          - aux1 -> PAUSE; aux2 and aux3 are ignored.
//          - Tick and aux1 in the same cycle: the decrement is applied, then PAUSE.
//            If that decrement reaches 0, DONE wins over PAUSE.
//   PAUSE: - bcd and prescaler are frozen.
//          - aux2 -> RUN (prescaler continues from its held value).
//          - aux1 -> IDLE with bcd cleared to 0.
//          - aux3 is ignored.
//   DONE:  - bcd = 0, alarm = 1.
//          - Any aux event -> IDLE with alarm = 0; that event has no other effect.
//  bcd never holds a non-BCD digit and never underflows below 00000000.
//  Reset asserted mid-operation returns everything to reset values with no clock edge needed.
//  Counting resumes only after a new aux2 following reset release.
// TESTING (bench uses PRESCALE=4, clean button pulses held 4 cycles)
//  1. Reset held low, then released -> bcd=0, running=0, paused=0, alarm=0, tick=0.
//     Pulse aux2 -> stays IDLE (value is zero).
//  2. Load digits:
//     dip=8'h03 + aux3, then dip=8'h12 + aux3 -> bcd=32'h00000023.
//     dip=8'h7F + aux3 -> bcd=32'h90000023 (value clamped to 9).
//  3. Borrow ripple: load 32'h00000100, then aux2.
//     First tick 4 cycles after RUN entry -> bcd=32'h00000099.
//     Next tick -> bcd=32'h00000098.
//  4. Reach zero: load 2, then aux2.
//     After 2 ticks -> bcd=0, alarm=1, running=0.
//     aux3 -> alarm=0, state IDLE, bcd unchanged at 0.
//  5. Pause and resume: load 5, aux2, aux1 mid-period.
//     -> paused=1; bcd and tick are frozen for 20 cycles.
//     aux2 -> next tick comes after the remaining prescaler cycles; bcd=4.
//     aux1 twice (pause, then clear) -> bcd=0, IDLE.
//  6. Async reset mid-RUN: load 32'h00001234, aux2, two ticks, drop reset between clock edges.
//     -> bcd=0 and running=0 before the next clk edge.
//  7. Same-cycle events:
//     aux1 and aux2 together in IDLE -> clear only.
//     Tick coinciding with aux1 on value 1 -> DONE.

Source files
------------

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   8-digit BCD countdown timer. Digits are loaded one at a time from the DIP
//   switches, then the value counts down by one every PRESCALE clock cycles.
//   The alarm output is raised when the value reaches zero.
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-low reset
//   dip        in   8   [6:4] digit index (0 = least significant), [3:0] value,
//                       [7] unused
//   aux1       in   1   active-low button: pause / clear / acknowledge
//   aux2       in   1   active-low button: start / resume / acknowledge
//   aux3       in   1   active-low button: write digit / acknowledge
//   bcd        out  32  eight BCD digits, digit k at bcd[4k+3:4k]
//   running    out  1   high while counting
//   paused     out  1   high while paused
//   alarm      out  1   high once the count has reached zero
//   tick       out  1   one-cycle pulse on each prescaler wrap while counting
//   dbg_state  out  2   current FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//
// Button events: each pin goes through a two-stage synchronizer followed by a
// falling-edge detector, so a press is a single event however long it is held.
// A pin sampled low at edge n produces an event that is acted on at edge n+2.
// When several events arrive in the same cycle, aux1 beats aux2 beats aux3.
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned PRESCALE = 120000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dip,
    input  logic        aux1,
    input  logic        aux2,
    input  logic        aux3,
    output logic [31:0] bcd,
    output logic        running,
    output logic        paused,
    output logic        alarm,
    output logic        tick,
    output logic [1:0]  dbg_state
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    bcd_q, bcd_d;
    logic [PW-1:0]  presc_q, presc_d;

    // Button synchronizers, bit order {aux3, aux2, aux1}. They reset to the
    // released (high) level so reset release never looks like a press.
    logic [2:0]     sync1_q, sync2_q, last_q;
    logic [2:0]     fall;
    logic           ev1, ev2, ev3, ev_any;

    logic           tick_c;
    logic [31:0]    bcd_dec_c;
    logic [3:0]     dip_val;

    logic           unused_dip7;
    assign unused_dip7 = dip[7];

    // BCD minus one with the borrow rippling up from digit 0.
    function automatic logic [31:0] bcd_dec(input logic [31:0] v);
        logic [31:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            last_q  <= 3'b111;
        end else begin
            sync1_q <= {aux3, aux2, aux1};
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
        end
    end

    assign fall   = last_q & ~sync2_q;
    assign ev1    = fall[0];
    assign ev2    = fall[1] & ~fall[0];
    assign ev3    = fall[2] & ~fall[1] & ~fall[0];
    assign ev_any = |fall;

    assign tick_c    = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    assign bcd_dec_c = bcd_dec(bcd_q);
    assign dip_val   = (dip[3:0] > 4'd9) ? 4'd9 : dip[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        presc_d = presc_q;
        unique case (state_q)
            S_IDLE: begin
                if (ev1) begin
                    bcd_d = '0;
                end else if (ev2) begin
                    // Starting from zero would alarm immediately; ignore it.
                    if (bcd_q != 32'd0) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end else if (ev3) begin
                    bcd_d[{dip[6:4], 2'b00} +: 4] = dip_val;
                end
            end
            S_RUN: begin
                presc_d = tick_c ? '0 : presc_q + 1'b1;
                if (tick_c) begin
                    bcd_d = bcd_dec_c;
                    // Reaching zero takes precedence over a same-cycle pause.
                    if (bcd_dec_c == 32'd0) begin
                        state_d = S_DONE;
                    end else if (ev1) begin
                        state_d = S_PAUSE;
                    end
                end else if (ev1) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (ev1) begin
                    state_d = S_IDLE;
                    bcd_d   = '0;
                end else if (ev2) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                bcd_d = '0;
                if (ev_any) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bcd       = bcd_q;
    assign running   = (state_q == S_RUN);
    assign paused    = (state_q == S_PAUSE);
    assign alarm     = (state_q == S_DONE);
    assign tick      = tick_c;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//   Directed scenarios followed by random button/DIP activity. A reference
//   model works on the count as a plain integer and pushes the expected
//   outputs {bcd, running, paused, alarm, tick} each cycle; a monitor pops
//   and compares them on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int P = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk;
    logic        reset;
    logic [7:0]  dip;
    logic        aux1, aux2, aux3;
    logic [31:0] bcd;
    logic        running, paused, alarm, tick;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_fail;
    logic        chk_en;

    logic [35:0] exp_q[$];

    countdown_timer #(.PRESCALE(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .dip       (dip),
        .aux1      (aux1),
        .aux2      (aux2),
        .aux3      (aux3),
        .bcd       (bcd),
        .running   (running),
        .paused    (paused),
        .alarm     (alarm),
        .tick      (tick),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned m_val;
    int          m_mode;
    int          m_presc;
    logic [2:0]  h1, h2, h3;   // pin samples from 1, 2 and 3 edges ago

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned t;
        t = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int unsigned pow10(input int k);
        int unsigned r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    always @(posedge clk) begin
        logic [2:0]  ev;
        logic        e1, e2, e3, tick_now, tick_next;
        int unsigned pw, d, nv;
        if (!reset) begin
            m_val   = 0;
            m_mode  = M_IDLE;
            m_presc = 0;
            h1 = 3'b111;
            h2 = 3'b111;
            h3 = 3'b111;
        end else begin
            // A press is acted on two edges after the low level was first sampled.
            ev = h3 & ~h2;
            e1 = ev[0];
            e2 = ev[1] && !ev[0];
            e3 = ev[2] && !ev[1] && !ev[0];
            tick_now = (m_mode == M_RUN) && (m_presc == P - 1);
            case (m_mode)
                M_IDLE: begin
                    if (e1) m_val = 0;
                    else if (e2) begin
                        if (m_val != 0) begin
                            m_mode  = M_RUN;
                            m_presc = 0;
                        end
                    end else if (e3) begin
                        pw = pow10(int'(dip[6:4]));
                        d  = (m_val / pw) % 10;
                        nv = (dip[3:0] > 9) ? 9 : int'(dip[3:0]);
                        m_val = m_val - d * pw + nv * pw;
                    end
                end
                M_RUN: begin
                    m_presc = (m_presc + 1) % P;
                    if (tick_now) m_val = m_val - 1;
                    if (tick_now && m_val == 0) m_mode = M_DONE;
                    else if (e1) m_mode = M_PAUSE;
                end
                M_PAUSE: begin
                    if (e1) begin
                        m_mode = M_IDLE;
                        m_val  = 0;
                    end else if (e2) m_mode = M_RUN;
                end
                default: begin
                    if (ev != 3'b000) m_mode = M_IDLE;
                end
            endcase
            h3 = h2;
            h2 = h1;
            h1 = {aux3, aux2, aux1};
            tick_next = (m_mode == M_RUN) && (m_presc == P - 1);
            if (chk_en)
                exp_q.push_back({to_bcd(m_val), m_mode == M_RUN, m_mode == M_PAUSE,
                                 m_mode == M_DONE, tick_next});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [35:0] e, a;
        if (chk_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bcd, running, paused, alarm, tick};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t {bcd,run,pause,alarm,tick} actual=%h expected=%h",
                         $time, a, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_pins(input logic [2:0] low_mask);
        aux1 = ~low_mask[0];
        aux2 = ~low_mask[1];
        aux3 = ~low_mask[2];
    endtask

    // Hold the selected buttons low for 4 cycles, then release them.
    task automatic press(input logic [2:0] mask);
        set_pins(mask);
        step(4);
        set_pins(3'b000);
    endtask

    task automatic load_digit(input logic [7:0] d);
        dip = d;
        press(3'b100);
        step(3);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Returns just after the clock edge that applied the next decrement.
    task automatic wait_tick(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s tick timeout actual=0 expected=1", name);
        end
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int hold;
        logic [2:0] mask;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        reset    = 1'b0;
        dip      = 8'h00;
        set_pins(3'b000);

        // 1. reset, start on zero is ignored
        step(3);
        check("reset_bcd", bcd, 32'h0);
        check("reset_flags", {28'h0, running, paused, alarm, tick}, 32'h0);
        reset = 1'b1;
        chk_en = 1'b1;
        step(2);
        press(3'b010);
        step(3);
        check("start_on_zero_running", {31'h0, running}, 32'h0);

        // 2. digit loads, value clamp
        load_digit(8'h03);
        load_digit(8'h12);
        check("load_23", bcd, 32'h00000023);
        load_digit(8'h7F);
        check("load_clamp", bcd, 32'h90000023);

        // 3. borrow ripple
        press(3'b001);
        step(3);
        check("clear_idle", bcd, 32'h0);
        load_digit(8'h21);
        check("load_100", bcd, 32'h00000100);
        press(3'b010);
        wait_tick("ripple1");
        check("ripple_99", bcd, 32'h00000099);
        wait_tick("ripple2");
        check("ripple_98", bcd, 32'h00000098);
        press(3'b001);
        step(3);
        press(3'b001);
        step(3);

        // 4. reach zero, acknowledge
        load_digit(8'h02);
        press(3'b010);
        wait_tick("zero1");
        wait_tick("zero2");
        check("zero_bcd", bcd, 32'h0);
        check("zero_flags", {29'h0, running, paused, alarm}, 32'h1);
        press(3'b100);
        step(3);
        check("ack_flags", {29'h0, running, paused, alarm}, 32'h0);
        check("ack_bcd", bcd, 32'h0);

        // 5. pause before the first tick, hold, resume
        load_digit(8'h05);
        set_pins(3'b010);
        step(1);
        set_pins(3'b011);
        step(3);
        set_pins(3'b000);
        step(2);
        check("pause_flag", {30'h0, running, paused}, 32'h1);
        step(20);
        check("pause_frozen", bcd, 32'h5);
        press(3'b010);
        wait_tick("resume");
        check("resume_4", bcd, 32'h4);
        press(3'b001);
        step(3);
        press(3'b001);
        step(3);
        check("pause_clear", bcd, 32'h0);
        check("pause_clear_flags", {30'h0, running, paused}, 32'h0);

        // 6. asynchronous reset while counting
        load_digit(8'h04);
        load_digit(8'h13);
        load_digit(8'h22);
        load_digit(8'h31);
        check("load_1234", bcd, 32'h00001234);
        press(3'b010);
        wait_tick("rst_t1");
        wait_tick("rst_t2");
        #1;
        chk_en = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        #1;
        check("async_bcd", bcd, 32'h0);
        check("async_running", {31'h0, running}, 32'h0);
        step(2);
        reset = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(10);
        check("post_reset_idle", {31'h0, running}, 32'h0);

        // 7. same-cycle events
        load_digit(8'h07);
        press(3'b011);
        step(3);
        check("clear_wins", bcd, 32'h0);
        check("clear_wins_run", {31'h0, running}, 32'h0);
        load_digit(8'h01);
        press(3'b010);
        press(3'b001);
        step(2);
        check("tick_aux1_done", {29'h0, running, paused, alarm}, 32'h1);
        press(3'b100);
        step(3);

        // Random phase
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            dip = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            if (r <= 3) mask = 3'b100;
            else if (r <= 5) mask = 3'b010;
            else if (r == 6) mask = 3'b001;
            else if (r == 7) mask = 3'b011;
            else if (r == 8) mask = 3'($urandom_range(0, 7));
            else mask = 3'b000;
            hold = $urandom_range(1, 6);
            set_pins(mask);
            step(hold);
            set_pins(3'b000);
            step((r == 9) ? $urandom_range(5, 30) : $urandom_range(0, 8));
        end

        step(6);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
